// File: rtl/rom_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_bus_arbiter
//  Purpose  : Shares one external ROM/SRAM chip between the SNES and the MCU.
//             SNES accesses have strict priority and are buffered in a
//             one-entry pending slot. MCU accesses fill the idle gaps. Every
//             access takes a fixed number of cycles. Completion is signalled
//             by a one-cycle SNES_RDY or MCU_ACK pulse.
//  Ports    : CLK, RST (async, active-high)
//             SNES_* : pulse request, translated address/data in, rdata/rdy out
//             MCU_*  : level request held until ACK, rdata/ack out
//             MEM_*  : external memory address, data out/in, OE_N, WE_N
//             BUSY   : access in progress
//             SNES_OVF : sticky flag, a SNES request was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module rom_bus_arbiter #(
   parameter int ROM_CYCLE_LEN = 7          // legal range 3..15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SNES_REQ,
   input  logic        SNES_WE,
   input  logic [23:0] SNES_ADDR_IN,
   input  logic [7:0]  SNES_WDATA,
   output logic [7:0]  SNES_RDATA,
   output logic        SNES_RDY,
   input  logic        MCU_REQ,
   input  logic        MCU_WE,
   input  logic [23:0] MCU_ADDR,
   input  logic [7:0]  MCU_WDATA,
   output logic [7:0]  MCU_RDATA,
   output logic        MCU_ACK,
   output logic [23:0] MEM_ADDR,
   output logic [7:0]  MEM_DQ_OUT,
   input  logic [7:0]  MEM_DQ_IN,
   output logic        MEM_OE_N,
   output logic        MEM_WE_N,
   output logic        BUSY,
   output logic        SNES_OVF
);

   // Final counter value of an access, and the last counter value from which
   // the next cycle still lies inside the write-strobe window (cnt 1..LEN-2).
   localparam logic [3:0] c_last_cnt   = 4'(ROM_CYCLE_LEN - 1);
   localparam logic [3:0] c_we_end_cnt = 4'(ROM_CYCLE_LEN - 3);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SNES = 2'd1,
      S_MCU  = 2'd2
   } state_t;

   state_t      state_q,      state_d;
   logic [3:0]  cnt_q,        cnt_d;
   logic        pend_q,       pend_d;
   logic [23:0] slot_addr_q,  slot_addr_d;
   logic        slot_we_q,    slot_we_d;
   logic [7:0]  slot_wdata_q, slot_wdata_d;
   logic        acc_we_q,     acc_we_d;
   logic [23:0] mem_addr_q,   mem_addr_d;
   logic [7:0]  mem_dq_out_q, mem_dq_out_d;
   logic        mem_oe_n_q,   mem_oe_n_d;
   logic        mem_we_n_q,   mem_we_n_d;
   logic [7:0]  snes_rdata_q, snes_rdata_d;
   logic [7:0]  mcu_rdata_q,  mcu_rdata_d;
   logic        snes_rdy_q,   snes_rdy_d;
   logic        mcu_ack_q,    mcu_ack_d;
   logic        busy_q,       busy_d;
   logic        snes_ovf_q,   snes_ovf_d;

   logic        w_last;
   logic        w_arb;
   logic        w_snes_avail;
   logic        w_mcu_ok;
   logic [23:0] w_sel_addr;
   logic        w_sel_we;
   logic [7:0]  w_sel_wdata;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         pend_q       <= 1'b0;
         slot_addr_q  <= 24'd0;
         slot_we_q    <= 1'b0;
         slot_wdata_q <= 8'd0;
         acc_we_q     <= 1'b0;
         mem_addr_q   <= 24'd0;
         mem_dq_out_q <= 8'd0;
         mem_oe_n_q   <= 1'b1;
         mem_we_n_q   <= 1'b1;
         snes_rdata_q <= 8'd0;
         mcu_rdata_q  <= 8'd0;
         snes_rdy_q   <= 1'b0;
         mcu_ack_q    <= 1'b0;
         busy_q       <= 1'b0;
         snes_ovf_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         slot_addr_q  <= slot_addr_d;
         slot_we_q    <= slot_we_d;
         slot_wdata_q <= slot_wdata_d;
         acc_we_q     <= acc_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_dq_out_q <= mem_dq_out_d;
         mem_oe_n_q   <= mem_oe_n_d;
         mem_we_n_q   <= mem_we_n_d;
         snes_rdata_q <= snes_rdata_d;
         mcu_rdata_q  <= mcu_rdata_d;
         snes_rdy_q   <= snes_rdy_d;
         mcu_ack_q    <= mcu_ack_d;
         busy_q       <= busy_d;
         snes_ovf_q   <= snes_ovf_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      slot_addr_d  = slot_addr_q;
      slot_we_d    = slot_we_q;
      slot_wdata_d = slot_wdata_q;
      acc_we_d     = acc_we_q;
      mem_addr_d   = mem_addr_q;
      mem_dq_out_d = mem_dq_out_q;
      mem_oe_n_d   = 1'b1;
      mem_we_n_d   = 1'b1;
      snes_rdata_d = snes_rdata_q;
      mcu_rdata_d  = mcu_rdata_q;
      snes_rdy_d   = 1'b0;
      mcu_ack_d    = 1'b0;
      snes_ovf_d   = snes_ovf_q;

      w_last = (state_q != S_IDLE) && (cnt_q == c_last_cnt);
      w_arb  = (state_q == S_IDLE) || w_last;

      // A request arriving on an arbitration edge is treated as already
      // pending, so the slot is bypassed when it is empty.
      w_snes_avail = pend_q || SNES_REQ;
      w_sel_addr   = pend_q ? slot_addr_q  : SNES_ADDR_IN;
      w_sel_we     = pend_q ? slot_we_q    : SNES_WE;
      w_sel_wdata  = pend_q ? slot_wdata_q : SNES_WDATA;

      // MCU_REQ is still high while its ACK is being produced or is on the
      // wire; it must not be mistaken for a fresh request.
      w_mcu_ok = MCU_REQ && !mcu_ack_q && !(w_last && (state_q == S_MCU));

      // Access completion: capture read data, pulse the owner's handshake.
      if (w_last) begin
         if (state_q == S_SNES) begin
            snes_rdy_d = 1'b1;
            if (!acc_we_q) snes_rdata_d = MEM_DQ_IN;
         end else begin
            mcu_ack_d = 1'b1;
            if (!acc_we_q) mcu_rdata_d = MEM_DQ_IN;
         end
      end

      // Access in progress: keep the strobes for the coming cycle.
      if ((state_q != S_IDLE) && !w_last) begin
         cnt_d      = cnt_q + 4'd1;
         mem_oe_n_d = acc_we_q;
         mem_we_n_d = !(acc_we_q && (cnt_q <= c_we_end_cnt));
      end

      // Arbitration: SNES first, then MCU, else idle.
      if (w_arb) begin
         cnt_d = 4'd0;
         if (w_snes_avail) begin
            state_d      = S_SNES;
            acc_we_d     = w_sel_we;
            mem_addr_d   = w_sel_addr;
            mem_dq_out_d = w_sel_wdata;
            mem_oe_n_d   = w_sel_we;
            mem_we_n_d   = 1'b1;
         end else if (w_mcu_ok) begin
            state_d      = S_MCU;
            acc_we_d     = MCU_WE;
            mem_addr_d   = MCU_ADDR;
            mem_dq_out_d = MCU_WDATA;
            mem_oe_n_d   = MCU_WE;
            mem_we_n_d   = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end

      // Pending slot maintenance.
      if (SNES_REQ) begin
         if (!pend_q) begin
            if (!w_arb) begin
               pend_d       = 1'b1;
               slot_addr_d  = SNES_ADDR_IN;
               slot_we_d    = SNES_WE;
               slot_wdata_d = SNES_WDATA;
            end
         end else if (w_arb) begin
            // Slot is consumed on this edge, so the new request refills it.
            pend_d       = 1'b1;
            slot_addr_d  = SNES_ADDR_IN;
            slot_we_d    = SNES_WE;
            slot_wdata_d = SNES_WDATA;
         end else begin
            snes_ovf_d = 1'b1;
         end
      end else if (w_arb && pend_q) begin
         pend_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   assign SNES_RDATA = snes_rdata_q;
   assign SNES_RDY   = snes_rdy_q;
   assign MCU_RDATA  = mcu_rdata_q;
   assign MCU_ACK    = mcu_ack_q;
   assign MEM_ADDR   = mem_addr_q;
   assign MEM_DQ_OUT = mem_dq_out_q;
   assign MEM_OE_N   = mem_oe_n_q;
   assign MEM_WE_N   = mem_we_n_q;
   assign BUSY       = busy_q;
   assign SNES_OVF   = snes_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_bus_arbiter
//  Purpose  : Self-checking bench for rom_bus_arbiter. Single accesses from
//             a vector table, then hand-written arbitration, overflow and
//             reset-abort sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_bus_arbiter;

   localparam int LEN = 7;

   logic        CLK = 1'b0;
   logic        RST;
   logic        SNES_REQ, SNES_WE;
   logic [23:0] SNES_ADDR_IN;
   logic [7:0]  SNES_WDATA, SNES_RDATA;
   logic        SNES_RDY;
   logic        MCU_REQ, MCU_WE;
   logic [23:0] MCU_ADDR;
   logic [7:0]  MCU_WDATA, MCU_RDATA;
   logic        MCU_ACK;
   logic [23:0] MEM_ADDR;
   logic [7:0]  MEM_DQ_OUT, MEM_DQ_IN;
   logic        MEM_OE_N, MEM_WE_N, BUSY, SNES_OVF;

   rom_bus_arbiter #(.ROM_CYCLE_LEN(LEN)) dut (
      .CLK(CLK), .RST(RST),
      .SNES_REQ(SNES_REQ), .SNES_WE(SNES_WE), .SNES_ADDR_IN(SNES_ADDR_IN),
      .SNES_WDATA(SNES_WDATA), .SNES_RDATA(SNES_RDATA), .SNES_RDY(SNES_RDY),
      .MCU_REQ(MCU_REQ), .MCU_WE(MCU_WE), .MCU_ADDR(MCU_ADDR),
      .MCU_WDATA(MCU_WDATA), .MCU_RDATA(MCU_RDATA), .MCU_ACK(MCU_ACK),
      .MEM_ADDR(MEM_ADDR), .MEM_DQ_OUT(MEM_DQ_OUT), .MEM_DQ_IN(MEM_DQ_IN),
      .MEM_OE_N(MEM_OE_N), .MEM_WE_N(MEM_WE_N), .BUSY(BUSY), .SNES_OVF(SNES_OVF)
   );

   always #5 CLK = ~CLK;

   // Memory model: fixed pattern, one special location.
   always_comb
      MEM_DQ_IN = (MEM_ADDR == 24'h123456) ? 8'hA5
                : (MEM_ADDR[7:0] ^ MEM_ADDR[15:8] ^ 8'h5A);

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Negedge monitor
   int          snes_rdy_n, snes_rdy_at, mcu_ack_n, mcu_ack_at;
   int          oe_low, we_low, busy_n, addr_err, dq_err;
   int          cap_cyc = -1;
   logic [23:0] cap_addr;
   logic        chk_en = 1'b0;
   logic        exp_we;
   logic [23:0] exp_addr;
   logic [7:0]  exp_dq;

   always @(negedge CLK) begin
      if (SNES_RDY) begin snes_rdy_n++; if (snes_rdy_n == 1) snes_rdy_at = cyc; end
      if (MCU_ACK)  begin mcu_ack_n++;  if (mcu_ack_n == 1)  mcu_ack_at  = cyc; end
      if (!MEM_OE_N) oe_low++;
      if (!MEM_WE_N) we_low++;
      if (BUSY) busy_n++;
      if (chk_en && BUSY && MEM_ADDR != exp_addr) addr_err++;
      if (chk_en && BUSY && exp_we && MEM_DQ_OUT != exp_dq) dq_err++;
   end

   task automatic clear_mon();
      snes_rdy_n = 0; snes_rdy_at = -1; mcu_ack_n = 0; mcu_ack_at = -1;
      oe_low = 0; we_low = 0; busy_n = 0; addr_err = 0; dq_err = 0;
   endtask

   // Inputs change 2 time units after the falling edge, after the monitor.
   task automatic wait_neg();
      @(negedge CLK);
      #2;
   endtask

   task automatic step(input int n);
      for (int t = 0; t < n; t++) begin
         if (MCU_REQ && MCU_ACK) MCU_REQ = 1'b0;
         wait_neg();
         if (cyc == cap_cyc) cap_addr = MEM_ADDR;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          mcu;
      bit          we;
      logic [23:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } vec_t;

   vec_t vecs[6];
   int   c0;

   initial begin
      vecs[0] = '{mcu: 1'b0, we: 1'b0, addr: 24'h123456, wdata: 8'h00, rdata: 8'hA5};
      vecs[1] = '{mcu: 1'b0, we: 1'b1, addr: 24'hE00010, wdata: 8'h3C, rdata: 8'h00};
      vecs[2] = '{mcu: 1'b1, we: 1'b0, addr: 24'h00ABCD, wdata: 8'h00, rdata: 8'h3C};
      vecs[3] = '{mcu: 1'b1, we: 1'b1, addr: 24'h7FFFFF, wdata: 8'hC3, rdata: 8'h00};
      vecs[4] = '{mcu: 1'b0, we: 1'b0, addr: 24'h7F0201, wdata: 8'h00, rdata: 8'h59};
      vecs[5] = '{mcu: 1'b1, we: 1'b0, addr: 24'h123456, wdata: 8'h00, rdata: 8'hA5};

      RST = 1'b1;
      SNES_REQ = 0; SNES_WE = 0; SNES_ADDR_IN = 0; SNES_WDATA = 0;
      MCU_REQ = 0; MCU_WE = 0; MCU_ADDR = 0; MCU_WDATA = 0;
      clear_mon();
      step(3);
      RST = 1'b0;
      step(2);

      // ---- Reset state ----
      chk("reset_oe_n",     32'(MEM_OE_N),   32'd1);
      chk("reset_we_n",     32'(MEM_WE_N),   32'd1);
      chk("reset_addr",     32'(MEM_ADDR),   32'd0);
      chk("reset_dq_out",   32'(MEM_DQ_OUT), 32'd0);
      chk("reset_rdata",    {SNES_RDATA, MCU_RDATA}, 32'd0);
      chk("reset_rdy_ack",  {SNES_RDY, MCU_ACK}, 32'd0);
      chk("reset_busy_ovf", {BUSY, SNES_OVF}, 32'd0);

      // ---- Table: single accesses from idle ----
      for (int i = 0; i < 6; i++) begin
         wait_neg();
         clear_mon();
         c0 = cyc;
         exp_we = vecs[i].we; exp_addr = vecs[i].addr; exp_dq = vecs[i].wdata;
         chk_en = 1'b1;
         if (vecs[i].mcu) begin
            MCU_REQ = 1; MCU_WE = vecs[i].we; MCU_ADDR = vecs[i].addr; MCU_WDATA = vecs[i].wdata;
         end else begin
            SNES_REQ = 1; SNES_WE = vecs[i].we; SNES_ADDR_IN = vecs[i].addr; SNES_WDATA = vecs[i].wdata;
         end
         wait_neg();
         SNES_REQ = 0;
         step(20);
         chk_en = 1'b0;
         if (vecs[i].mcu) begin
            chk($sformatf("v%0d_ack_cnt", i), 32'(mcu_ack_n), 32'd1);
            chk($sformatf("v%0d_ack_at", i), 32'(mcu_ack_at - c0), 32'(LEN + 1));
            chk($sformatf("v%0d_no_rdy", i), 32'(snes_rdy_n), 32'd0);
            if (!vecs[i].we) chk($sformatf("v%0d_mcu_rdata", i), 32'(MCU_RDATA), 32'(vecs[i].rdata));
         end else begin
            chk($sformatf("v%0d_rdy_cnt", i), 32'(snes_rdy_n), 32'd1);
            chk($sformatf("v%0d_rdy_at", i), 32'(snes_rdy_at - c0), 32'(LEN + 1));
            chk($sformatf("v%0d_no_ack", i), 32'(mcu_ack_n), 32'd0);
            if (!vecs[i].we) chk($sformatf("v%0d_snes_rdata", i), 32'(SNES_RDATA), 32'(vecs[i].rdata));
         end
         chk($sformatf("v%0d_oe_low", i), 32'(oe_low), vecs[i].we ? 32'd0 : 32'(LEN));
         chk($sformatf("v%0d_we_low", i), 32'(we_low), vecs[i].we ? 32'(LEN - 2) : 32'd0);
         chk($sformatf("v%0d_busy", i), 32'(busy_n), 32'(LEN));
         chk($sformatf("v%0d_addr_dq_err", i), 32'(addr_err + dq_err), 32'd0);
      end

      // ---- SNES and MCU on the same edge: SNES first, MCU with no gap ----
      wait_neg();
      clear_mon();
      c0 = cyc;
      cap_cyc = c0 + LEN + 1;
      SNES_REQ = 1; SNES_WE = 0; SNES_ADDR_IN = 24'h000111;
      MCU_REQ = 1; MCU_WE = 1; MCU_ADDR = 24'h000222; MCU_WDATA = 8'h77;
      wait_neg();
      SNES_REQ = 0;
      step(25);
      chk("sim_rdy_at", 32'(snes_rdy_at - c0), 32'(LEN + 1));
      chk("sim_ack_at", 32'(mcu_ack_at - c0), 32'(2 * LEN + 1));
      chk("sim_busy_nogap", 32'(busy_n), 32'(2 * LEN));
      chk("sim_mcu_addr", 32'(cap_addr), 32'h000222);
      chk("sim_snes_rdata", 32'(SNES_RDATA), 32'h4A);
      chk("sim_we_low", 32'(we_low), 32'(LEN - 2));

      // ---- SNES request during MCU access at cnt=2 ----
      wait_neg();
      clear_mon();
      c0 = cyc;
      MCU_REQ = 1; MCU_WE = 0; MCU_ADDR = 24'h000333;
      step(3);                             // now in cycle c0+3: MCU cnt = 2
      SNES_REQ = 1; SNES_WE = 0; SNES_ADDR_IN = 24'h000444;
      step(1);
      SNES_REQ = 0;
      step(25);
      chk("mid_ack_at", 32'(mcu_ack_at - c0), 32'(LEN + 1));
      chk("mid_rdy_at", 32'(snes_rdy_at - c0), 32'(2 * LEN + 1));
      chk("mid_mcu_rdata", 32'(MCU_RDATA), 32'h6A);
      chk("mid_snes_rdata", 32'(SNES_RDATA), 32'h1A);
      chk("mid_ovf_clear", 32'(SNES_OVF), 32'd0);

      // ---- Two SNES requests during one MCU access: overflow ----
      wait_neg();
      clear_mon();
      c0 = cyc;
      cap_cyc = c0 + LEN + 1;
      MCU_REQ = 1; MCU_WE = 1; MCU_ADDR = 24'h000555; MCU_WDATA = 8'h99;
      step(2);
      SNES_REQ = 1; SNES_WE = 0; SNES_ADDR_IN = 24'h000666;
      step(1);
      SNES_ADDR_IN = 24'h000777;
      step(1);
      SNES_REQ = 0;
      step(25);
      chk("ovf_flag", 32'(SNES_OVF), 32'd1);
      chk("ovf_rdy_cnt", 32'(snes_rdy_n), 32'd1);
      chk("ovf_first_served", 32'(cap_addr), 32'h000666);
      chk("ovf_snes_rdata", 32'(SNES_RDATA), 32'h3A);
      chk("ovf_ack_at", 32'(mcu_ack_at - c0), 32'(LEN + 1));

      // ---- Reset at cnt=3 of a SNES write ----
      wait_neg();
      clear_mon();
      SNES_REQ = 1; SNES_WE = 1; SNES_ADDR_IN = 24'h000888; SNES_WDATA = 8'h11;
      wait_neg();                          // cnt = 0
      SNES_REQ = 0;
      step(3);                             // cnt = 3
      chk("rst_pre_we_low", 32'(MEM_WE_N), 32'd0);
      chk("rst_pre_busy", 32'(BUSY), 32'd1);
      RST = 1'b1;
      #1;
      chk("rst_we_n", 32'(MEM_WE_N), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_ovf", 32'(SNES_OVF), 32'd0);
      wait_neg();
      RST = 1'b0;
      clear_mon();
      step(15);
      chk("rst_no_rdy", 32'(snes_rdy_n), 32'd0);
      chk("rst_stays_idle", 32'(busy_n), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
